// File: rtl/logic_sweep_ctrl.sv
// Input-vector controller for the switch-to-LED combinational stage: manual passthrough or
// automatic 16-vector sweep with hit counting. Optional LOOP_SWEEP_EN makes the sweep repeat.
module logic_sweep_ctrl #(
    parameter int unsigned DEBOUNCE_LIMIT = 250000,
    parameter int unsigned STEP_CYCLES    = 25000000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Mode_Btn,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    input  logic       i_Switch_4,
    output logic [3:0] o_Vec,
    input  logic [2:0] i_Result,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4,
    output logic       o_Done,
    output logic [4:0] o_Hit_Count
);

    localparam int unsigned DbW   = $clog2(DEBOUNCE_LIMIT + 1);
    localparam int unsigned StepW = $clog2(STEP_CYCLES);

    typedef enum logic [1:0] {StManual, StSweep, StDone} state_t;

    state_t             state_q, state_d;
    logic               btn_meta_q, btn_sync_q;
    logic [DbW-1:0]     db_cnt_q, db_cnt_d;
    logic               db_level_q, db_level_d, db_level_prev_q;
    logic [StepW-1:0]   step_q, step_d;
    logic [3:0]         vec_q, vec_d;
    logic [4:0]         hits_q, hits_d;
    logic               done_q, done_d;
    logic [2:0]         led_q;
    logic               press;
    logic               terminal;
    logic [3:0]         switches;

    assign switches = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};
    assign press    = db_level_q & ~db_level_prev_q;
    assign terminal = (step_q == StepW'(STEP_CYCLES - 1));

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q         <= StManual;
            btn_meta_q      <= 1'b0;
            btn_sync_q      <= 1'b0;
            db_cnt_q        <= '0;
            db_level_q      <= 1'b0;
            db_level_prev_q <= 1'b0;
            step_q          <= '0;
            vec_q           <= '0;
            hits_q          <= '0;
            done_q          <= 1'b0;
            led_q           <= '0;
        end else begin
            state_q         <= state_d;
            btn_meta_q      <= i_Mode_Btn;
            btn_sync_q      <= btn_meta_q;
            db_cnt_q        <= db_cnt_d;
            db_level_q      <= db_level_d;
            db_level_prev_q <= db_level_q;
            step_q          <= step_d;
            vec_q           <= vec_d;
            hits_q          <= hits_d;
            done_q          <= done_d;
            led_q           <= i_Result;
        end
    end

    // Counter only runs while the synced level disagrees; any agreement restarts it.
    always_comb begin
        db_cnt_d   = '0;
        db_level_d = db_level_q;
        if (btn_sync_q != db_level_q) begin
            if (db_cnt_q == DbW'(DEBOUNCE_LIMIT - 1)) begin
                db_level_d = ~db_level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        step_d  = step_q;
        hits_d  = hits_q;
        done_d  = done_q;
        unique case (state_q)
            StManual: begin
                vec_d  = switches;
                done_d = 1'b0;
                if (press) begin
                    state_d = StSweep;
                    vec_d   = '0;
                    step_d  = '0;
                    hits_d  = '0;
                end
            end
            StSweep: begin
                done_d = 1'b0;
                // Abort takes priority over the terminal-cycle sample.
                if (press) begin
                    state_d = StManual;
                    vec_d   = switches;
                end else if (terminal) begin
                    hits_d = hits_q + {4'b0000, i_Result[0]};
                    if (vec_q != 4'hF) begin
                        vec_d  = vec_q + 4'd1;
                        step_d = '0;
                    end else begin
`ifdef LOOP_SWEEP_EN
                        vec_d  = '0;
                        step_d = '0;
                        hits_d = {4'b0000, i_Result[0]};
                        done_d = 1'b1;
`else
                        state_d = StDone;
                        done_d  = 1'b1;
`endif
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            StDone: begin
                done_d = 1'b1;
                if (press) begin
                    state_d = StManual;
                    done_d  = 1'b0;
                    vec_d   = switches;
                end
            end
            default: state_d = StManual;
        endcase
    end

    assign o_Vec       = vec_q;
    assign o_Hit_Count = hits_q;
    assign o_Done      = done_q;
    assign o_LED_1     = led_q[0];
    assign o_LED_2     = led_q[1];
    assign o_LED_3     = led_q[2];
    assign o_LED_4     = (state_q != StManual);

endmodule
